// File: rtl/fetch_unit_pkg.sv
// Shared state encodings, widths and the buffered-instruction record for the fetch stage.
package fetch_unit_pkg;

    localparam int          ILEN    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic pc_aligned(input logic [ILEN-1:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO, W bits wide and DEPTH (power of two) entries deep.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: pushes while full are dropped unless a pop frees a slot that cycle; flush beats push.
module fetch_fifo #(
    parameter  int W     = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_dat,
    output logic [W-1:0]  o_dat,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_count   = r_cnt;
    assign o_dat     = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr] <= i_dat;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem read in flight, buffers {pc,inst} for decode.
// Latency: request on the first cycle out of reset; a response in cycle N is at the decode port in N+1.
// Backpressure: stops issuing while the buffer has no free slot; redirects squash buffer and in-flight read.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misaligned_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        r_state;
    state_t        w_next;
    state_t        w_rst_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic          r_fault;
    logic          r_halt_pend;
    logic          w_redir;
    logic          w_misal;
    logic          w_redir_ok;
    logic          w_room;
    logic          w_req_vld;
    logic          w_req_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_tail;

    // Once halted (or heading there behind a wrong-path response) redirects are ignored.
    assign w_redir    = redirect_valid && (r_state != S_HALT) && !r_halt_pend;
    assign w_misal    = w_redir && !pc_aligned(redirect_pc);
    assign w_redir_ok = w_redir && !w_misal;
    assign w_room     = (w_count < CW'(FIFO_DEPTH));
    assign w_req_fire = w_req_vld && imem_req_ready;
    assign w_push     = (r_state == S_WAIT) && imem_rsp_valid && !w_redir && !rst;
    assign w_pop      = inst_valid && inst_ready;
    assign w_tail     = '{pc: r_req_pc, inst: imem_rsp_data};

    fetch_fifo #(
        .W     (2 * ILEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .i_dat   (w_tail),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A read still in flight at reset must be swallowed, so reset may land in S_FLUSH.
    assign w_rst_state = ((r_state == S_WAIT || r_state == S_FLUSH) && !imem_rsp_valid) ? S_FLUSH : S_REQ;

    always_ff @(posedge clk) begin
        if (rst) r_state <= w_rst_state;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_REQ: begin
                if (w_misal)         w_next = S_HALT;
                else if (w_req_fire) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_redir)             w_next = imem_rsp_valid ? (w_misal ? S_HALT : S_REQ) : S_FLUSH;
                else if (imem_rsp_valid) w_next = S_REQ;
            end
            S_FLUSH: begin
                if (imem_rsp_valid) w_next = (r_halt_pend || w_misal) ? S_HALT : S_REQ;
            end
            S_HALT: w_next = S_HALT;
        endcase
    end

    always_comb begin
        w_req_vld        = (r_state == S_REQ) && w_room && !rst && !w_redir;
        imem_req_valid   = w_req_vld;
        imem_req_addr    = r_pc;
        inst_valid       = !w_empty;
        inst             = w_empty ? '0 : w_head.inst;
        inst_pc          = w_empty ? '0 : w_head.pc;
        misaligned_fault = r_fault;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_fault     <= 1'b0;
            r_halt_pend <= 1'b0;
        end else if (w_misal) begin
            r_fault     <= 1'b1;
            r_halt_pend <= (r_state != S_REQ) && !imem_rsp_valid;
        end else if (w_redir_ok) begin
            r_pc <= redirect_pc;
        end else if (w_req_fire) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + PC_STEP;
        end
    end

    // The issue rule reserves a slot for every outstanding read.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(w_push && w_full && !w_pop));
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the architectural PC, issues word reads to instruction memory, and buffers fetched instructions for decode.
- Sits upstream of decode and the execute ALUs; consumes next_pc redirects from the branch ALU.
- Keeps at most one memory request outstanding and discards wrong-path responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >=2.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word address of request (byte address, [1:0]=0).
- imem_rsp_valid  in  1  read data valid; one response per accepted request, always accepted.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  buffered instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  instruction at FIFO head.
- inst_pc  out  32  PC of inst.
- redirect_valid  in  1  branch/jump taken; load new PC.
- redirect_pc  in  32  target PC (next_pc from branch ALU).
- misaligned_fault  out  1  sticky; redirect target had [1:0]!=0.

Behaviour:
- Reset (rst high at posedge): pc<=RESET_PC, state<=S_REQ, FIFO empty, misaligned_fault<=0. Registered outputs then: imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0; imem_req_addr shows pc (RESET_PC).
- States: S_REQ, S_WAIT, S_FLUSH, S_HALT.
- S_REQ: imem_req_valid=1 iff FIFO has >=1 free entry, rst low, and no redirect this cycle. Request addr = pc. On req_valid&req_ready: req_pc<=pc, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), go S_WAIT.
- S_WAIT: imem_req_valid=0. On rsp_valid: push {req_pc, rsp_data} to FIFO, go S_REQ. Space is guaranteed by the issue rule.
- S_FLUSH: the outstanding response is wrong-path. On rsp_valid: drop it, go S_REQ.
- S_HALT: no requests; responses ignored; leaves only on rst.
- Redirect (redirect_valid=1, target aligned), highest priority after rst:
  - pc<=redirect_pc and FIFO cleared (inst_valid=0 next cycle).
  - From S_REQ: no request is issued that cycle (req_valid forced 0); stay S_REQ.
  - From S_WAIT without rsp_valid: go S_FLUSH.
  - From S_WAIT with rsp_valid the same cycle: response dropped, go S_REQ.
  - From S_FLUSH with rsp_valid: go S_REQ; without rsp_valid: stay S_FLUSH.
- Misaligned redirect (redirect_pc[1:0]!=0): misaligned_fault<=1, FIFO cleared, pc unchanged. Go S_HALT, or S_FLUSH-then-S_HALT if a response is outstanding.
- Decode side:
  - inst_valid = FIFO not empty; inst/inst_pc = head entry.
  - Pop on inst_valid&inst_ready.
  - Pop and push in the same cycle are both honoured.
  - Pop in the same cycle as redirect: flush wins, the popped entry is still delivered that cycle.
- Latency: request on the first cycle rst is low. Response arriving in cycle N gives inst_valid in cycle N+1. Best-case throughput is one instruction per 2 cycles.
- rst mid-transaction: any outstanding response arriving after reset must be dropped. Reset therefore enters S_FLUSH when it was asserted in S_WAIT/S_FLUSH with a request outstanding; otherwise it enters S_REQ.

Decomposition:
- Shared include/package: state encodings (S_REQ=2'd0, S_WAIT=2'd1, S_FLUSH=2'd2, S_HALT=2'd3), ILEN=32, PC_STEP=4.
- Sub-module fetch_fifo: synchronous FIFO.
  - Width 64 ({pc,inst}), depth FIFO_DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - Flush has priority over push.

Test Plan:
- Reset, mem ready always, 1-cycle response: req addrs 0x0,0x4,0x8; inst_pc sequence 0x0,0x4,0x8 with matching data; inst_ready=1.
- inst_ready=0 for 10 cycles: FIFO fills to 2 entries, imem_req_valid deasserts. On release, data is delivered in order with no loss or duplication.
- Redirect to 0x100 while in S_WAIT, response arrives 3 cycles later: response dropped, next req addr 0x100, first inst_pc=0x100.
- Redirect to 0x200 coincident with rsp_valid: response dropped, FIFO empty, next req addr 0x200.
- Redirect to 0x102: misaligned_fault=1 permanently, no further requests; after rst, fault=0 and req addr=RESET_PC.
- PC at 0xFFFF_FFFC: next req addr 0x0000_0000.
